lisnoc_mp_simple_host: RTL and testbench
========================================

LISNOC_MP_SIMPLE_HOST -- requirements
Module: lisnoc_mp_simple_host

Interface
REQ-001 Parameter noc_data_width, default 32, bus and flit data width.
REQ-002 Parameter fifo_depth, default 16, slave packet buffer depth; size_width = clog2(fifo_depth+1), which is 5 at the default.
REQ-003 Port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port bus_addr  output  6  byte address to the message-passing slave.
REQ-006 Port bus_we / bus_en  output  1 each  write strobe / transfer request.
REQ-007 Port bus_data_out  output  noc_data_width  write data (size or flit).
REQ-008 Port bus_data_in  input  noc_data_width  read data from the slave.
REQ-009 Port bus_ack  input  1  transfer completion; a transfer completes at any rising edge where bus_en and bus_ack are both high.
REQ-010 Port irq  input  1  slave has a received packet pending.
REQ-011 Port tx_req / tx_size  input  1 / size_width  packet send request and flit count.
REQ-012 Port tx_gnt  output  1  one-cycle pulse: request accepted, tx_size consumed.
REQ-013 Port tx_valid / tx_data / tx_ready  in / in / out  1 / noc_data_width / 1  outgoing flit stream.
REQ-014 Port rx_valid / rx_data / rx_last / rx_ready  out / out / out / in  1 / noc_data_width / 1 / 1  received flit stream.

Function
REQ-015 The block SHALL use one FSM with states IDLE, TX_SIZE, TX_FLIT, RX_SIZE and RX_FLIT, plus TX_POLL under REQ-030.
REQ-016 IDLE SHALL keep bus_en=0.
- If only tx_req is pending, IDLE SHALL go to TX_SIZE.
- If only irq is high, IDLE SHALL go to RX_SIZE.
- If both are pending, IDLE SHALL serve the direction not served last; a last_rx bit resets to 0, so RX is served first.
REQ-017 On leaving IDLE for TX, the block SHALL pulse tx_gnt and latch tx_size into a remaining counter.
- If tx_size==0, the block SHALL pulse tx_gnt and stay in IDLE with no bus activity.
REQ-018 TX_SIZE SHALL drive bus_en=1, bus_we=1, bus_addr=0x00 and bus_data_out = zero-extended size; on completion it SHALL go to TX_FLIT.
REQ-019 TX_FLIT SHALL drive bus_en=tx_valid, bus_we=1, bus_addr=0x00, bus_data_out=tx_data and tx_ready=bus_ack, all combinationally.
- Each completion SHALL decrement the counter.
- When the counter reaches 0, TX_FLIT SHALL go to IDLE and set last_rx=0.
REQ-020 tx_size values above fifo_depth SHALL be forwarded unchanged, without checking.
REQ-021 RX_SIZE SHALL drive bus_en=1, bus_we=0, bus_addr=0x00; on completion it SHALL latch bus_data_in[size_width-1:0] as the counter.
- If the latched value is 0 (spurious irq), RX_SIZE SHALL go to IDLE.
- Otherwise RX_SIZE SHALL go to RX_FLIT.
REQ-022 RX_FLIT SHALL drive bus_en = (!rx_valid | rx_ready), bus_we=0, bus_addr=0x00.
- Each completion SHALL load bus_data_in into the rx_data register, set rx_valid=1 and rx_last=(counter==1), and decrement the counter.
REQ-023 The receive output is a one-entry register: rx_valid SHALL clear on rx_valid&rx_ready unless it is reloaded in the same cycle.
- Back-to-back flits at one per cycle SHALL be possible while rx_ready=1.
REQ-024 When the counter reaches 0 in RX_FLIT, the FSM SHALL go to IDLE and set last_rx=1.
- The final flit may still be pending in the rx register; a new RX_FLIT load SHALL wait until it drains, per REQ-022.
REQ-025 irq SHALL be sampled only in IDLE; deassertion mid-packet SHALL be ignored.
REQ-026 Outside TX_FLIT and unused bus phases, bus_data_out SHALL be 0, and tx_ready SHALL be 0 outside TX_FLIT.

Reset
REQ-027 Asserting rst SHALL immediately set state=IDLE, last_rx=0, counter=0, rx_valid=0, rx_last=0, rx_data=0 and tx_gnt=0.
- bus_en, bus_we and tx_ready SHALL therefore be 0 during reset.
REQ-028 Reset mid-packet SHALL abandon the packet with no further bus transfers; resynchronising with the slave is the system's responsibility (slave shares rst).
REQ-029 After rst deasserts, the first transfer SHALL start no earlier than the second rising edge.

Configuration
REQ-030 Macro LISNOC_MP_SIMPLE_HOST_POLL_EN:
- Defined: a TX request SHALL enter TX_POLL before TX_SIZE. TX_POLL reads bus_addr=0x10 (bus_en=1, bus_we=0) and repeats until bus_data_in[0]==1, meaning output buffer empty. tx_gnt SHALL pulse on entry to TX_POLL.
- Undefined: TX_POLL SHALL not exist, and IDLE SHALL go directly to TX_SIZE.

Verification
REQ-031 Send: tx_size=3, flits 0xA,0xB,0xC, ack always high -> writes at 0x00 of 3, 0xA, 0xB, 0xC on four consecutive edges; tx_gnt pulses once.
REQ-032 Receive: irq=1, slave returns size 2 then 0x11, 0x22, rx_ready=1 -> rx flits 0x11 (last=0) and 0x22 (last=1); FSM back in IDLE.
REQ-033 Backpressure: rx_ready=0 after the first flit for 5 cycles -> bus_en=0 for those cycles; no flit lost or duplicated.
REQ-034 Contention: tx_req and irq both high from reset -> RX packet first, then TX; repeat the conflict -> RX first again (alternation).
REQ-035 Spurious irq (size read returns 0) -> exactly one read at 0x00 and return to IDLE with rx_valid=0. Also tx_size=0 -> tx_gnt pulse and no bus activity.
REQ-036 Assert rst during flit 2 of a 4-flit send -> bus_en=0 in the same cycle; state IDLE; with the macro defined, 0x10 is polled before every size write.

Source files
------------

// File: rtl/lisnoc_mp_simple_host.sv
// -----------------------------------------------------------------------------
// lisnoc_mp_simple_host
//
// Host-side bridge between a simple packet stream interface and a
// message-passing slave reached over a small request/acknowledge bus.
// A send writes the flit count followed by each flit to address 0x00.
// A receive reads the flit count from 0x00, then reads that many flits.
// When TX and RX are both pending, the block serves whichever direction
// it did not serve last.
//
// Parameters
//   noc_data_width : bus and flit data width
//   fifo_depth     : slave packet buffer depth (sets size_width)
//
// Ports
//   clk, rst               : clock, asynchronous active-high reset
//   bus_addr/we/en         : bus byte address, write strobe, transfer request
//   bus_data_out/in        : bus write / read data
//   bus_ack                : transfer completes on an edge with bus_en & bus_ack
//   irq                    : slave holds a received packet
//   tx_req/tx_size/tx_gnt  : send request, flit count, one-cycle accept pulse
//   tx_valid/data/ready    : outgoing flit stream
//   rx_valid/data/last/
//   rx_ready               : received flit stream (one-entry output register)
//
// Build option
//   LISNOC_MP_SIMPLE_HOST_POLL_EN : before each send, poll address 0x10
//   until bit 0 (output buffer empty) reads as 1.
// -----------------------------------------------------------------------------
module lisnoc_mp_simple_host #(
  parameter int noc_data_width = 32,
  parameter int fifo_depth     = 16,
  localparam int size_width    = $clog2(fifo_depth + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [5:0]                bus_addr,
  output logic                      bus_we,
  output logic                      bus_en,
  output logic [noc_data_width-1:0] bus_data_out,
  input  logic [noc_data_width-1:0] bus_data_in,
  input  logic                      bus_ack,
  input  logic                      irq,
  input  logic                      tx_req,
  input  logic [size_width-1:0]     tx_size,
  output logic                      tx_gnt,
  input  logic                      tx_valid,
  input  logic [noc_data_width-1:0] tx_data,
  output logic                      tx_ready,
  output logic                      rx_valid,
  output logic [noc_data_width-1:0] rx_data,
  output logic                      rx_last,
  input  logic                      rx_ready
);

  typedef enum logic [2:0] {
    IDLE,
    TX_SIZE,
    TX_FLIT,
    RX_SIZE,
    RX_FLIT
`ifdef LISNOC_MP_SIMPLE_HOST_POLL_EN
    , TX_POLL
`endif
  } state_e;

`ifdef LISNOC_MP_SIMPLE_HOST_POLL_EN
  localparam state_e TX_FIRST = TX_POLL;
`else
  localparam state_e TX_FIRST = TX_SIZE;
`endif

  localparam logic [size_width-1:0] ONE = size_width'(1);

  state_e                    state_q, state_d;
  logic [size_width-1:0]     counter_q, counter_d;
  logic                      last_rx_q, last_rx_d;
  logic                      tx_gnt_q, tx_gnt_d;
  logic                      rx_valid_q, rx_valid_d;
  logic                      rx_last_q, rx_last_d;
  logic [noc_data_width-1:0] rx_data_q, rx_data_d;
  logic                      tx_pending;
  logic                      rx_size_zero;

  // A request is consumed by the grant; while the grant pulse is out the
  // requester has not yet had a chance to drop tx_req, so ignore it then.
  assign tx_pending   = tx_req & ~tx_gnt_q;
  assign rx_size_zero = (bus_data_in[size_width-1:0] == '0);

  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    last_rx_d    = last_rx_q;
    tx_gnt_d     = 1'b0;
    rx_data_d    = rx_data_q;
    rx_last_d    = rx_last_q;
    rx_valid_d   = rx_valid_q & ~rx_ready;
    bus_en       = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_data_out = '0;
    tx_ready     = 1'b0;

    case (state_q)
      IDLE: begin
        if (irq && (!tx_pending || !last_rx_q)) begin
          state_d = RX_SIZE;
        end else if (tx_pending) begin
          tx_gnt_d  = 1'b1;
          counter_d = tx_size;
          if (tx_size != '0) begin
            state_d = TX_FIRST;
          end else begin
            last_rx_d = 1'b0;
          end
        end
      end

`ifdef LISNOC_MP_SIMPLE_HOST_POLL_EN
      TX_POLL: begin
        bus_en   = 1'b1;
        bus_addr = 6'h10;
        if (bus_ack && bus_data_in[0]) begin
          state_d = TX_SIZE;
        end
      end
`endif

      TX_SIZE: begin
        bus_en                        = 1'b1;
        bus_we                        = 1'b1;
        bus_data_out[size_width-1:0]  = counter_q;
        if (bus_ack) begin
          state_d = TX_FLIT;
        end
      end

      TX_FLIT: begin
        bus_en       = tx_valid;
        bus_we       = 1'b1;
        bus_data_out = tx_data;
        tx_ready     = bus_ack;
        if (tx_valid && bus_ack) begin
          counter_d = counter_q - ONE;
          if (counter_q == ONE) begin
            state_d   = IDLE;
            last_rx_d = 1'b0;
          end
        end
      end

      RX_SIZE: begin
        bus_en = 1'b1;
        if (bus_ack) begin
          counter_d = bus_data_in[size_width-1:0];
          if (rx_size_zero) begin
            // Spurious interrupt still counts as an RX turn so a stuck irq
            // cannot starve pending sends.
            state_d   = IDLE;
            last_rx_d = 1'b1;
          end else begin
            state_d = RX_FLIT;
          end
        end
      end

      RX_FLIT: begin
        bus_en = ~rx_valid_q | rx_ready;
        if (bus_en && bus_ack) begin
          rx_data_d  = bus_data_in;
          rx_valid_d = 1'b1;
          rx_last_d  = (counter_q == ONE);
          counter_d  = counter_q - ONE;
          if (counter_q == ONE) begin
            state_d   = IDLE;
            last_rx_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      last_rx_q  <= 1'b0;
      tx_gnt_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_last_q  <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      last_rx_q  <= last_rx_d;
      tx_gnt_q   <= tx_gnt_d;
      rx_valid_q <= rx_valid_d;
      rx_last_q  <= rx_last_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign tx_gnt   = tx_gnt_q;
  assign rx_valid = rx_valid_q;
  assign rx_last  = rx_last_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_lisnoc_mp_simple_host.sv
// -----------------------------------------------------------------------------
// Testbench for lisnoc_mp_simple_host: a slave/source/sink environment driven
// from one initial block, with expected bus transactions and received flits
// built per packet from the message-passing protocol rules.
// -----------------------------------------------------------------------------
module tb_lisnoc_mp_simple_host;

`ifdef LISNOC_MP_SIMPLE_HOST_POLL_EN
  localparam int POLL_N = 1;
`else
  localparam int POLL_N = 0;
`endif

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
    int          cyc;
  } xfer_t;

  logic        clk;
  logic        rst;
  logic [5:0]  bus_addr;
  logic        bus_we;
  logic        bus_en;
  logic [31:0] bus_data_out;
  logic [31:0] bus_data_in;
  logic        bus_ack;
  logic        irq;
  logic        tx_req;
  logic [4:0]  tx_size;
  logic        tx_gnt;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_last;
  logic        rx_ready;

  xfer_t       act_q[$];
  xfer_t       exp_q[$];
  logic [32:0] rx_act[$];
  logic [32:0] rx_exp[$];
  logic [31:0] rdq[$];
  logic [31:0] txq[$];

  int ack_pct = 100;
  int val_pct = 100;
  int rdy_pct = 100;
  int cyc = 0;
  int gnt_cnt = 0;
  int vectors = 0;
  int miscompares = 0;

  lisnoc_mp_simple_host #(
    .noc_data_width(32),
    .fifo_depth    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus_addr    (bus_addr),
    .bus_we      (bus_we),
    .bus_en      (bus_en),
    .bus_data_out(bus_data_out),
    .bus_data_in (bus_data_in),
    .bus_ack     (bus_ack),
    .irq         (irq),
    .tx_req      (tx_req),
    .tx_size     (tx_size),
    .tx_gnt      (tx_gnt),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_last     (rx_last),
    .rx_ready    (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void exp_push(logic we, logic [5:0] a, logic [31:0] d);
    xfer_t e;
    e.we   = we;
    e.addr = a;
    e.data = d;
    e.cyc  = 0;
    exp_q.push_back(e);
  endfunction

  // Send packet: [poll], size write, one write per flit, all at 0x00.
  task automatic load_tx(int n, logic [31:0] base, logic [31:0] stp);
    logic [31:0] d;
    logic [31:0] sz;
    sz      = 32'(n);
    tx_size = sz[4:0];
    if (n != 0) begin
      if (POLL_N != 0) exp_push(1'b0, 6'h10, 32'h1);
      exp_push(1'b1, 6'h00, sz);
    end
    for (int i = 0; i < n; i++) begin
      d = (base != 0) ? base + stp * 32'(i) : $urandom();
      txq.push_back(d);
      exp_push(1'b1, 6'h00, d);
    end
    tx_req = 1'b1;
  endtask

  // Receive packet: size read (upper bits random unless directed), then
  // one read per flit; only the low size_width bits carry the count.
  task automatic load_rx(int n, logic [31:0] base, logic [31:0] stp);
    logic [31:0] d;
    logic [31:0] w;
    logic [31:0] nn;
    nn      = 32'(n);
    w       = (base != 0) ? nn : $urandom();
    w[4:0]  = nn[4:0];
    rdq.push_back(w);
    exp_push(1'b0, 6'h00, w);
    for (int i = 0; i < n; i++) begin
      d = (base != 0) ? base + stp * 32'(i) : $urandom();
      rdq.push_back(d);
      exp_push(1'b0, 6'h00, d);
      rx_exp.push_back({(i == n - 1), d});
    end
    irq = 1'b1;
  endtask

  // One clock of environment: observe at negedge, update inputs after posedge.
  task automatic cycle();
    logic  done;
    logic  rd0;
    logic  txc;
    logic  gnt_seen;
    xfer_t e;
    @(negedge clk);
    bus_data_in = (bus_addr == 6'h10) ? 32'h1 : ((rdq.size() != 0) ? rdq[0] : 32'h0);
    #1;
    done = !rst && bus_en && bus_ack;
    rd0  = done && !bus_we && (bus_addr == 6'h00);
    txc  = !rst && tx_valid && tx_ready;
    if (done) begin
      e.we   = bus_we;
      e.addr = bus_addr;
      e.data = bus_we ? bus_data_out : bus_data_in;
      e.cyc  = cyc;
      act_q.push_back(e);
    end
    if (!rst && rx_valid && rx_ready) rx_act.push_back({rx_last, rx_data});
    gnt_seen = !rst && tx_gnt;
    if (gnt_seen) gnt_cnt++;
    @(posedge clk);
    cyc++;
    #1;
    if (rd0 && rdq.size() != 0) void'(rdq.pop_front());
    if (txc && txq.size() != 0) void'(txq.pop_front());
    if (gnt_seen) tx_req = 1'b0;
    irq      = (rdq.size() != 0);
    bus_ack  = ($urandom_range(99) < ack_pct);
    tx_valid = (txq.size() != 0) && ($urandom_range(99) < val_pct);
    tx_data  = (txq.size() != 0) ? txq[0] : 32'h0;
    rx_ready = ($urandom_range(99) < rdy_pct);
    #1;
  endtask

  task automatic settle(string tag);
    int quiet;
    int n;
    quiet = 0;
    n     = 0;
    while (quiet < 4 && n < 3000) begin
      cycle();
      n++;
      if (!bus_en && !rx_valid && rdq.size() == 0 && txq.size() == 0 && !tx_req) quiet++;
      else quiet = 0;
    end
    check({tag, "_done_in_time"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic compare(string tag);
    int n;
    check({tag, "_nxfer"}, 64'(act_q.size()), 64'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check({tag, "_xfer"}, {25'b0, act_q[i].we, act_q[i].addr, act_q[i].data},
            {25'b0, exp_q[i].we, exp_q[i].addr, exp_q[i].data});
    check({tag, "_nrx"}, 64'(rx_act.size()), 64'(rx_exp.size()));
    n = (rx_act.size() < rx_exp.size()) ? rx_act.size() : rx_exp.size();
    for (int i = 0; i < n; i++)
      check({tag, "_rxflit"}, 64'(rx_act[i]), 64'(rx_exp[i]));
    act_q.delete();
    exp_q.delete();
    rx_act.delete();
    rx_exp.delete();
  endtask

  initial begin
    int c0;
    int n;
    int sz;
    logic is_tx;

    rst         = 1'b1;
    bus_ack     = 1'b1;
    bus_data_in = 32'h0;
    irq         = 1'b0;
    tx_req      = 1'b0;
    tx_size     = 5'd0;
    tx_valid    = 1'b0;
    tx_data     = 32'h0;
    rx_ready    = 1'b1;

    // Contention from reset: RX first (last_rx resets to 0), then TX.
    load_rx(2, 0, 0);
    load_tx(3, 0, 0);
    #3;
    check("rst_bus_en",   64'(bus_en),       64'd0);
    check("rst_bus_we",   64'(bus_we),       64'd0);
    check("rst_tx_ready", 64'(tx_ready),     64'd0);
    check("rst_tx_gnt",   64'(tx_gnt),       64'd0);
    check("rst_rx_valid", 64'(rx_valid),     64'd0);
    check("rst_rx_last",  64'(rx_last),      64'd0);
    check("rst_rx_data",  64'(rx_data),      64'd0);
    check("rst_bus_dout", 64'(bus_data_out), 64'd0);
    repeat (3) cycle();
    rst = 1'b0;
    c0  = cyc;
    settle("contend1");
    if (act_q.size() != 0) check("first_xfer_edge", 64'(act_q[0].cyc), 64'(c0 + 1));
    check("contend1_gnt", 64'(gnt_cnt), 64'd1);
    compare("contend1");

    // Repeat the conflict: TX was served last, so RX first again.
    gnt_cnt = 0;
    load_rx(3, 0, 0);
    load_tx(2, 0, 0);
    settle("contend2");
    compare("contend2");

    // After an RX-only packet, a conflict goes to TX first.
    load_rx(1, 0, 0);
    settle("rx_alone");
    compare("rx_alone");
    load_tx(2, 0, 0);
    load_rx(2, 0, 0);
    settle("contend3");
    compare("contend3");

    // Directed send 3 flits 0xA,0xB,0xC with ack always high.
    gnt_cnt = 0;
    load_tx(3, 32'hA, 32'h1);
    settle("send3");
    if (act_q.size() == POLL_N + 4)
      for (int i = 1; i < 4; i++)
        check("send3_consecutive", 64'(act_q[POLL_N + i].cyc), 64'(act_q[POLL_N].cyc + i));
    check("send3_gnt", 64'(gnt_cnt), 64'd1);
    compare("send3");

    // Directed receive: size 2, flits 0x11 and 0x22.
    load_rx(2, 32'h11, 32'h11);
    settle("recv2");
    compare("recv2");

    // Backpressure: hold rx_ready low for 5 cycles after the first flit.
    load_rx(3, 0, 0);
    n = 0;
    while (rx_act.size() < 1 && n < 100) begin
      cycle();
      n++;
    end
    check("bp_first_flit_seen", 64'(rx_act.size()), 64'd1);
    rdy_pct  = 0;
    rx_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_bus_en_low", 64'(bus_en),   64'd0);
      check("bp_rx_held",    64'(rx_valid), 64'd1);
      cycle();
    end
    rdy_pct  = 100;
    rx_ready = 1'b1;
    settle("backpressure");
    compare("backpressure");

    // Spurious irq: size word with zero low bits -> single read, no flits.
    rdq.push_back(32'hFFFF_FFE0);
    exp_push(1'b0, 6'h00, 32'hFFFF_FFE0);
    irq = 1'b1;
    settle("spurious");
    check("spurious_rx_valid", 64'(rx_valid), 64'd0);
    compare("spurious");

    // Zero-length send: grant only.
    gnt_cnt = 0;
    load_tx(0, 0, 0);
    settle("tx_zero");
    check("tx_zero_gnt", 64'(gnt_cnt), 64'd1);
    compare("tx_zero");

    // Size above fifo_depth goes through unchanged, with random handshakes.
    ack_pct = 60;
    val_pct = 70;
    load_tx(20, 0, 0);
    settle("tx_big");
    compare("tx_big");

    // Random packets with random bus/stream timing.
    for (int p = 0; p < 12; p++) begin
      ack_pct = $urandom_range(40, 100);
      val_pct = $urandom_range(40, 100);
      rdy_pct = $urandom_range(40, 100);
      gnt_cnt = 0;
      sz      = $urandom_range(0, 6);
      is_tx   = 1'($urandom_range(1));
      if (is_tx) load_tx(sz, 0, 0);
      else       load_rx(sz, 0, 0);
      settle("rand");
      check("rand_gnt", 64'(gnt_cnt), 64'(is_tx));
      compare("rand");
    end

    // Reset during flit 2 of a 4-flit send.
    ack_pct  = 100;
    val_pct  = 100;
    rdy_pct  = 100;
    rx_ready = 1'b1;
    load_tx(4, 0, 0);
    n = 0;
    while (act_q.size() < POLL_N + 2 && n < 100) begin
      cycle();
      n++;
    end
    check("pre_rst_bus_en", 64'(bus_en), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_bus_en",   64'(bus_en),   64'd0);
    check("midrst_bus_we",   64'(bus_we),   64'd0);
    check("midrst_tx_ready", 64'(tx_ready), 64'd0);
    check("midrst_tx_gnt",   64'(tx_gnt),   64'd0);
    check("midrst_rx_valid", 64'(rx_valid), 64'd0);
    txq.delete();
    tx_req = 1'b0;
    while (exp_q.size() > POLL_N + 2) void'(exp_q.pop_back());
    repeat (3) cycle();
    rst = 1'b0;
    settle("midrst");
    compare("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
